// File: rtl/flash_arb_pkg.sv
// Shared constants for the flash read arbiter and the requesters that sit on it.
// Default geometry matches the audio player's flash port.
package flash_arb_pkg;

  localparam int FLASH_ADDR_W = 23;
  localparam int FLASH_DATA_W = 32;

  // Arbiter FSM encoding (plain constants so older code can decode the state bits)
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE      = 2'd0;
  localparam arb_state_t ISSUE     = 2'd1;
  localparam arb_state_t WAIT_DATA = 2'd2;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first set request bit after last_grant,
// wrapping modulo NUM_REQ, as a one-hot vector and as an index.
module rr_priority_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx,
  output logic                       grant_valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_valid && req[(int'(last_grant) + k) % NUM_REQ]) begin
        grant_valid = 1'b1;
        grant[(int'(last_grant) + k) % NUM_REQ] = 1'b1;
        grant_idx = IDX_W'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// Round-robin arbiter sharing one Avalon-style flash read port between NUM_REQ
// readers, one outstanding read at a time, with a timeout to recover a dead read.
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = FLASH_ADDR_W,
  parameter int DATA_W  = FLASH_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic                        CLK_50M,
  input  logic                        RESET_N,
  input  logic [NUM_REQ-1:0]          req_read,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_address,
  output logic [NUM_REQ-1:0]          req_waitrequest,
  output logic [NUM_REQ-1:0]          req_readdatavalid,
  output logic [DATA_W-1:0]           req_readdata,
  output logic [NUM_REQ-1:0]          req_error,
  output logic                        flash_mem_read,
  output logic [ADDR_W-1:0]           flash_mem_address,
  input  logic                        flash_mem_waitrequest,
  input  logic                        flash_mem_readdatavalid,
  input  logic [DATA_W-1:0]           flash_mem_readdata,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   last_grant;
  logic [15:0]        timeout_cnt;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_valid;
  logic [ADDR_W-1:0]  pick_addr;
  logic               timeout_hit;

  rr_priority_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req         (req_read),
    .last_grant  (last_grant),
    .grant       (pick_onehot),
    .grant_idx   (pick_idx),
    .grant_valid (pick_valid)
  );

  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_onehot[i]) pick_addr = req_address[i*ADDR_W +: ADDR_W];
    end
  end

  // Counter starts at 0 on acceptance, so WAIT_DATA lasts exactly TIMEOUT cycles
  assign timeout_hit = (timeout_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge CLK_50M or negedge RESET_N) begin
    if (!RESET_N) begin
      state             <= IDLE;
      grant_id          <= '0;
      last_grant        <= IDX_W'(NUM_REQ - 1);
      flash_mem_address <= '0;
      timeout_cnt       <= '0;
      req_error         <= '0;
    end else begin
      req_error <= '0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id          <= pick_idx;
            flash_mem_address <= pick_addr;
            state             <= ISSUE;
          end
        end
        ISSUE: begin
          if (!flash_mem_waitrequest) begin
            timeout_cnt <= '0;
            state       <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          timeout_cnt <= timeout_cnt + 16'd1;
          if (flash_mem_readdatavalid) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end else if (timeout_hit) begin
            req_error[grant_id] <= 1'b1;
            last_grant          <= grant_id;
            state               <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign flash_mem_read = (state == ISSUE);
  assign busy           = (state != IDLE);
  assign req_readdata   = flash_mem_readdata;

  // Handshake and data strobe are routed combinationally to the granted requester only
  always_comb begin
    req_waitrequest   = '1;
    req_readdatavalid = '0;
    if (state == ISSUE) req_waitrequest[grant_id] = flash_mem_waitrequest;
    if (state == WAIT_DATA && flash_mem_readdatavalid) req_readdatavalid[grant_id] = 1'b1;
  end

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Self-checking bench for flash_read_arbiter: scenario tasks plus randomized
// traffic checked against a round-robin model of the grant order.
module tb_flash_read_arbiter;

  localparam int NR = 2;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 20;

  logic              CLK_50M;
  logic              RESET_N;
  logic [NR-1:0]     req_read;
  logic [NR*AW-1:0]  req_address;
  logic [NR-1:0]     req_waitrequest;
  logic [NR-1:0]     req_readdatavalid;
  logic [DW-1:0]     req_readdata;
  logic [NR-1:0]     req_error;
  logic              flash_mem_read;
  logic [AW-1:0]     flash_mem_address;
  logic              flash_mem_waitrequest;
  logic              flash_mem_readdatavalid;
  logic [DW-1:0]     flash_mem_readdata;
  logic              busy;
  logic [0:0]        grant_id;

  int n_cmp = 0;
  int n_bad = 0;
  int last_served;
  logic [AW-1:0] addr_tab [NR];

  flash_read_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK_50M                 (CLK_50M),
    .RESET_N                 (RESET_N),
    .req_read                (req_read),
    .req_address             (req_address),
    .req_waitrequest         (req_waitrequest),
    .req_readdatavalid       (req_readdatavalid),
    .req_readdata            (req_readdata),
    .req_error               (req_error),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .flash_mem_readdata      (flash_mem_readdata),
    .busy                    (busy),
    .grant_id                (grant_id)
  );

  initial CLK_50M = 1'b0;
  always #10 CLK_50M = ~CLK_50M;

  task automatic tick();
    @(posedge CLK_50M);
    @(negedge CLK_50M);
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr_tab[i] = a;
    req_address[i*AW +: AW] = a;
  endtask

  // Round-robin rule: first requesting index after the last one served, wrapping
  function automatic int rr_expect(input logic [NR-1:0] mask);
    int idx;
    for (int k = 1; k <= NR; k++) begin
      idx = (last_served + k) % NR;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  // Acts as the flash: stalls n_wait cycles, returns data lat cycles after acceptance
  task automatic serve_read(input int n_wait, input int lat, input logic [DW-1:0] data,
                            input bit drop, output int g, output logic [AW-1:0] a,
                            output int own_low, output int other_low, output int strobes,
                            output int strobe_id, output logic [DW-1:0] sdata,
                            output int read_in_wait, output bit started);
    int guard;
    own_low = 0; other_low = 0; strobes = 0; strobe_id = -1; sdata = '0;
    read_in_wait = 0; g = -1; a = '0; started = 0; guard = 0;
    flash_mem_waitrequest = 1'b1;
    while (flash_mem_read !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    if (flash_mem_read !== 1'b1) return;
    started = 1;
    g = int'(grant_id);
    a = flash_mem_address;
    for (int i = 0; i <= n_wait; i++) begin
      flash_mem_waitrequest = (i < n_wait);
      #1;
      for (int b = 0; b < NR; b++) begin
        if (req_waitrequest[b] === 1'b0) begin
          if (b == g) own_low++; else other_low++;
        end
        if (req_readdatavalid[b] === 1'b1) begin
          strobes++; strobe_id = b; sdata = req_readdata;
        end
      end
      tick();
    end
    flash_mem_waitrequest = 1'b1;
    if (drop) req_read[g] = 1'b0;
    for (int i = 0; i < lat; i++) begin
      flash_mem_readdatavalid = (i == lat - 1);
      flash_mem_readdata = (i == lat - 1) ? data : $urandom;
      #1;
      if (flash_mem_read === 1'b1) read_in_wait++;
      for (int b = 0; b < NR; b++) begin
        if (req_waitrequest[b] === 1'b0) begin
          if (b == g) own_low++; else other_low++;
        end
        if (req_readdatavalid[b] === 1'b1) begin
          strobes++; strobe_id = b; sdata = req_readdata;
        end
      end
      tick();
    end
    flash_mem_readdatavalid = 1'b0;
  endtask

  task automatic test_reset();
    RESET_N = 1'b0;
    req_read = '0;
    req_address = '0;
    flash_mem_waitrequest = 1'b1;
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata = '0;
    tick();
    tick();
    n_cmp++; if (flash_mem_read !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_read: got %0b, expected 0", flash_mem_read); end
    n_cmp++; if (flash_mem_address !== '0) begin n_bad++; $display("[TB] FAIL reset_addr: got %0h, expected 0", flash_mem_address); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_busy: got %0b, expected 0", busy); end
    n_cmp++; if (grant_id !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_grant: got %0d, expected 0", grant_id); end
    n_cmp++; if (req_waitrequest !== 2'b11) begin n_bad++; $display("[TB] FAIL reset_waitreq: got %b, expected 11", req_waitrequest); end
    n_cmp++; if (req_readdatavalid !== 2'b00 || req_error !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_strobes: got rdv=%b err=%b, expected 00/00", req_readdatavalid, req_error); end
    RESET_N = 1'b1;
    last_served = NR - 1;
    tick();
  endtask

  task automatic test_single();
    int g, own_low, other_low, strobes, sid, riw;
    logic [AW-1:0] a;
    logic [DW-1:0] sd;
    bit started;
    set_addr(0, 23'h00010);
    req_read = 2'b01;
    serve_read(2, 3, 32'hDEADBEEF, 1, g, a, own_low, other_low, strobes, sid, sd, riw, started);
    req_read = '0;
    n_cmp++; if (!started) begin n_bad++; $display("[TB] FAIL single_start: got no flash read, expected one"); end
    n_cmp++; if (g != 0) begin n_bad++; $display("[TB] FAIL single_grant: got %0d, expected 0", g); end
    n_cmp++; if (a !== 23'h00010) begin n_bad++; $display("[TB] FAIL single_addr: got %0h, expected 10", a); end
    n_cmp++; if (own_low != 1 || other_low != 0) begin n_bad++; $display("[TB] FAIL single_waitreq_low: got own=%0d other=%0d, expected 1/0", own_low, other_low); end
    n_cmp++; if (strobes != 1 || sid != 0) begin n_bad++; $display("[TB] FAIL single_strobe: got %0d strobes on %0d, expected 1 on 0", strobes, sid); end
    n_cmp++; if (sd !== 32'hDEADBEEF) begin n_bad++; $display("[TB] FAIL single_data: got %h, expected deadbeef", sd); end
    n_cmp++; if (riw != 0) begin n_bad++; $display("[TB] FAIL single_read_dropped: got %0d read cycles in wait, expected 0", riw); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL single_busy_after: got %0b, expected 0", busy); end
    if (started) last_served = g;
    tick();
  endtask

  task automatic test_contention();
    int g, prev_g, exp, own_low, other_low, strobes, sid, riw;
    logic [AW-1:0] a;
    logic [DW-1:0] sd, data;
    bit started;
    prev_g = -1;
    req_read = 2'b11;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NR; i++) set_addr(i, AW'($urandom));
      exp = rr_expect(req_read);
      data = $urandom;
      serve_read($urandom_range(0, 2), $urandom_range(1, 4), data, 0, g, a, own_low, other_low, strobes, sid, sd, riw, started);
      n_cmp++; if (g != exp || g == prev_g) begin n_bad++; $display("[TB] FAIL contention_grant[%0d]: got %0d (prev %0d), expected %0d", t, g, prev_g, exp); end
      n_cmp++; if (exp >= 0 && a !== addr_tab[exp]) begin n_bad++; $display("[TB] FAIL contention_addr[%0d]: got %0h, expected %0h", t, a, addr_tab[exp]); end
      n_cmp++; if (strobes != 1 || sid != exp || sd !== data) begin n_bad++; $display("[TB] FAIL contention_data[%0d]: got %0d strobes on %0d data %h, expected 1 on %0d data %h", t, strobes, sid, sd, exp, data); end
      n_cmp++; if (other_low != 0) begin n_bad++; $display("[TB] FAIL contention_other_waitreq[%0d]: got %0d, expected 0", t, other_low); end
      if (started) last_served = g;
      prev_g = g;
    end
    req_read = '0;
    tick();
  endtask

  task automatic test_timeout();
    int guard, g, own_low, other_low, strobes, sid, riw;
    bit early_err;
    logic [AW-1:0] a;
    logic [DW-1:0] sd;
    bit started;
    set_addr(1, 23'h12345);
    set_addr(0, 23'h00ABC);
    req_read = 2'b10;
    guard = 0;
    while (flash_mem_read !== 1'b1 && guard < 10) begin tick(); guard++; end
    n_cmp++; if (flash_mem_read !== 1'b1 || grant_id !== 1'b1) begin n_bad++; $display("[TB] FAIL timeout_grant: got read=%0b grant=%0d, expected 1/1", flash_mem_read, grant_id); end
    flash_mem_waitrequest = 1'b0;
    tick();
    flash_mem_waitrequest = 1'b1;
    req_read = 2'b01;
    early_err = 0;
    for (int k = 1; k <= TO; k++) begin
      tick();
      if (k < TO && (req_error !== 2'b00 || busy !== 1'b1)) early_err = 1;
    end
    n_cmp++; if (early_err) begin n_bad++; $display("[TB] FAIL timeout_early: got error/idle before %0d cycles, expected none", TO); end
    n_cmp++; if (req_error !== 2'b10) begin n_bad++; $display("[TB] FAIL timeout_error: got %b, expected 10", req_error); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("[TB] FAIL timeout_idle: got busy %0b, expected 0", busy); end
    last_served = 1;
    tick();
    n_cmp++; if (req_error !== 2'b00) begin n_bad++; $display("[TB] FAIL timeout_error_width: got %b, expected 00", req_error); end
    n_cmp++; if (flash_mem_read !== 1'b1 || int'(grant_id) != rr_expect(2'b01)) begin n_bad++; $display("[TB] FAIL timeout_next_grant: got read=%0b grant=%0d, expected 1/0", flash_mem_read, grant_id); end
    serve_read(0, 2, 32'hCAFE0001, 1, g, a, own_low, other_low, strobes, sid, sd, riw, started);
    req_read = '0;
    n_cmp++; if (a !== 23'h00ABC || sd !== 32'hCAFE0001 || sid != 0) begin n_bad++; $display("[TB] FAIL timeout_followup: got addr %0h data %h id %0d, expected abc/cafe0001/0", a, sd, sid); end
    if (started) last_served = g;
    tick();
  endtask

  task automatic test_stray_valid();
    logic [DW-1:0] d;
    bit bad_strobe, bad_data;
    bad_strobe = 0; bad_data = 0;
    req_read = '0;
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      flash_mem_readdatavalid = 1'($urandom_range(0, 1));
      flash_mem_readdata = d;
      #1;
      if (req_readdatavalid !== 2'b00 || busy !== 1'b0) bad_strobe = 1;
      if (req_readdata !== d) bad_data = 1;
      tick();
    end
    flash_mem_readdatavalid = 1'b0;
    n_cmp++; if (bad_strobe) begin n_bad++; $display("[TB] FAIL stray_valid: got a strobe or busy in IDLE, expected none"); end
    n_cmp++; if (bad_data) begin n_bad++; $display("[TB] FAIL readdata_passthrough: got differing readdata, expected copy of flash data"); end
  endtask

  task automatic test_reset_mid_read();
    int guard, g, own_low, other_low, strobes, sid, riw;
    logic [AW-1:0] a;
    logic [DW-1:0] sd;
    bit started;
    set_addr(0, 23'h0F0F0);
    set_addr(1, 23'h7AAAA);
    req_read = 2'b10;
    guard = 0;
    while (flash_mem_read !== 1'b1 && guard < 10) begin tick(); guard++; end
    n_cmp++; if (int'(grant_id) != 1) begin n_bad++; $display("[TB] FAIL midreset_pre_grant: got %0d, expected 1", grant_id); end
    flash_mem_waitrequest = 1'b0;
    tick();
    flash_mem_waitrequest = 1'b1;
    req_read = '0;
    tick();
    tick();
    RESET_N = 1'b0;
    #1;
    n_cmp++; if (flash_mem_read !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("[TB] FAIL midreset_idle: got read=%0b busy=%0b, expected 0/0", flash_mem_read, busy); end
    tick();
    RESET_N = 1'b1;
    last_served = NR - 1;
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata = 32'h0BADF00D;
    #1;
    n_cmp++; if (req_readdatavalid !== 2'b00) begin n_bad++; $display("[TB] FAIL midreset_late_valid: got %b, expected 00", req_readdatavalid); end
    tick();
    flash_mem_readdatavalid = 1'b0;
    req_read = 2'b11;
    serve_read(1, 2, 32'h13572468, 1, g, a, own_low, other_low, strobes, sid, sd, riw, started);
    req_read = '0;
    n_cmp++; if (g != rr_expect(2'b11) || a !== 23'h0F0F0) begin n_bad++; $display("[TB] FAIL midreset_first_grant: got %0d addr %0h, expected 0 addr f0f0", g, a); end
    if (started) last_served = g;
    tick();
  endtask

  task automatic test_back_to_back();
    int g, own_low, other_low, strobes, sid, riw;
    logic [AW-1:0] a;
    logic [DW-1:0] sd;
    bit started;
    set_addr(0, 23'h00200);
    req_read = 2'b01;
    serve_read(0, 1, 32'h11112222, 0, g, a, own_low, other_low, strobes, sid, sd, riw, started);
    if (started) last_served = g;
    n_cmp++; if (flash_mem_read !== 1'b0) begin n_bad++; $display("[TB] FAIL b2b_gap: got read %0b one cycle after strobe, expected 0", flash_mem_read); end
    tick();
    n_cmp++; if (flash_mem_read !== 1'b1 || int'(grant_id) != rr_expect(2'b01)) begin n_bad++; $display("[TB] FAIL b2b_reissue: got read=%0b grant=%0d two cycles after strobe, expected 1/0", flash_mem_read, grant_id); end
    serve_read(0, 1, 32'h33334444, 1, g, a, own_low, other_low, strobes, sid, sd, riw, started);
    req_read = '0;
    n_cmp++; if (sd !== 32'h33334444 || sid != 0) begin n_bad++; $display("[TB] FAIL b2b_data: got %h on %0d, expected 33334444 on 0", sd, sid); end
    if (started) last_served = g;
    tick();
  endtask

  task automatic test_random();
    int g, exp, own_low, other_low, strobes, sid, riw;
    logic [AW-1:0] a;
    logic [DW-1:0] sd, data;
    logic [NR-1:0] mask;
    bit started;
    for (int t = 0; t < 12; t++) begin
      mask = NR'($urandom_range(1, 3));
      for (int i = 0; i < NR; i++) set_addr(i, AW'($urandom));
      req_read = mask;
      exp = rr_expect(mask);
      data = $urandom;
      serve_read($urandom_range(0, 3), $urandom_range(1, 5), data, 0, g, a, own_low, other_low, strobes, sid, sd, riw, started);
      n_cmp++; if (g != exp || (exp >= 0 && a !== addr_tab[exp])) begin n_bad++; $display("[TB] FAIL random_grant[%0d]: got %0d addr %0h, expected %0d mask %b", t, g, a, exp, mask); end
      n_cmp++; if (strobes != 1 || sid != exp || sd !== data || own_low != 1) begin n_bad++; $display("[TB] FAIL random_data[%0d]: got %0d strobes on %0d data %h wlow %0d, expected 1 on %0d data %h wlow 1", t, strobes, sid, sd, own_low, exp, data); end
      if (started) last_served = g;
    end
    req_read = '0;
    tick();
  endtask

  initial begin
    @(negedge CLK_50M);
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_stray_valid();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/flash_read_arbiter.md
Name: flash_read_arbiter

Overview:
- Shares the single Avalon-style flash read port (read/address/waitrequest/readdatavalid/readdata) among NUM_REQ requesters.
- Typical requesters: the audio sample player and a second reader, such as a waveform or visualiser fetcher.
- Round-robin grant; one outstanding read at a time; the read-data strobe is routed back to the granted requester.
- A timeout counter recovers the port if the flash never returns data.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 23, flash word address width.
- DATA_W, 32, flash read data width.
- TIMEOUT, 255, WAIT_DATA cycles before the read is aborted (max 2^16-1).

Ports:
- CLK_50M  in  1  system clock.
- RESET_N  in  1  asynchronous active-low reset.
- req_read  in  NUM_REQ  per-requester read request; held until its req_waitrequest bit is low.
- req_address  in  NUM_REQ*ADDR_W  per-requester address; slice i = [i*ADDR_W +: ADDR_W].
- req_waitrequest  out  NUM_REQ  1 = request not yet accepted.
- req_readdatavalid  out  NUM_REQ  one-cycle strobe, data valid for requester i.
- req_readdata  out  DATA_W  broadcast copy of flash_mem_readdata.
- req_error  out  NUM_REQ  one-cycle strobe, read for requester i timed out.
- flash_mem_read  out  1  flash read request.
- flash_mem_address  out  ADDR_W  flash address.
- flash_mem_waitrequest  in  1  flash stall.
- flash_mem_readdatavalid  in  1  flash data valid.
- flash_mem_readdata  in  DATA_W  flash data.
- busy  out  1  high in ISSUE or WAIT_DATA.
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.

Behaviour:
- Reset (async, RESET_N=0):
  - state=IDLE; flash_mem_read=0; flash_mem_address=0.
  - grant_id=0; last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
  - timeout counter=0; busy=0; req_waitrequest=all 1; req_readdatavalid=0; req_error=0.
- IDLE:
  - If no req_read bit is set, stay in IDLE.
  - Otherwise select the first set bit scanning last_grant+1, last_grant+2, … modulo NUM_REQ.
  - Register grant_id and the selected address into flash_mem_address; go to ISSUE.
  - Latency: request seen at cycle n, flash_mem_read=1 at cycle n+1.
- ISSUE:
  - flash_mem_read=1; address held.
  - req_waitrequest[grant_id] = flash_mem_waitrequest (combinational); all other bits are 1.
  - When flash_mem_waitrequest=0: next state WAIT_DATA; flash_mem_read=0 next cycle; timeout counter cleared.
- WAIT_DATA:
  - flash_mem_read=0; counter increments each cycle.
  - On flash_mem_readdatavalid=1:
    - req_readdatavalid[grant_id]=1 in the same cycle (combinational route).
    - req_readdata=flash_mem_readdata.
    - last_grant<=grant_id; go to IDLE.
  - If counter==TIMEOUT without valid data:
    - req_error[grant_id]=1 for one cycle (registered).
    - last_grant<=grant_id; go to IDLE.
  - readdatavalid in the timeout cycle takes priority over the error.
- At least one IDLE cycle separates transactions, giving a maximum of one read per 3 cycles plus flash latency.
- Stray inputs:
  - flash_mem_readdatavalid outside WAIT_DATA is ignored; no strobe is produced.
  - A requester dropping req_read while in ISSUE (protocol violation) does not abort the read. The latched address still completes and the data strobe is still routed to grant_id.
- Simultaneous requests: round-robin guarantees each active requester is served within NUM_REQ transactions.
- Reset mid-transaction returns the block immediately to IDLE. Any later readdatavalid is ignored because it arrives in IDLE.
- req_readdata is always a pass-through of flash_mem_readdata; consumers qualify it with their readdatavalid bit.

Decomposition:
- Package flash_arb_pkg holds:
  - the state enum {IDLE, ISSUE, WAIT_DATA};
  - the default ADDR_W/DATA_W constants shared with the audio player.
- One combinational sub-module rr_priority_picker (inputs req vector and last_grant; outputs a one-hot grant and its index) keeps the round-robin scan separate and reusable.

Test Plan:
- Single requester: req_read[0]=1, addr 0x00010. Flash waitrequest=1 for 2 cycles, then readdatavalid 3 cycles later with 0xDEADBEEF. Required: flash_mem_address=0x00010, req_waitrequest[0] low exactly once, req_readdatavalid[0] pulses once with req_readdata=0xDEADBEEF, busy falls the next cycle.
- Contention: both requesters hold req_read continuously. Required: grants alternate 0,1,0,1 over 4 transactions, each receiving its own address's data.
- Timeout: grant requester 1 and never assert readdatavalid. Required: req_error[1] pulses exactly TIMEOUT cycles after acceptance, state returns to IDLE, the next grant goes to requester 0 if it is requesting.
- Stray valid: assert flash_mem_readdatavalid while in IDLE. Required: no req_readdatavalid bit toggles.
- Reset mid-read: drop RESET_N during WAIT_DATA, then release. Required: flash_mem_read=0, busy=0, the first grant goes to requester 0, a late readdatavalid is ignored.
- Back-to-back: requester 0 re-requests immediately after its strobe while requester 1 is idle. Required: flash_mem_read re-asserts 2 cycles after the strobe (via one IDLE cycle).
